lsu_mem_arbiter: RTL
====================

// Module: lsu_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between the LSU lanes of a VLIW bundle.
//  Each lane presents a decoded load/store (is_load, zero_ext, size, rd) plus its
//  computed address and store data. The block round-robin arbitrates between lanes
//  and drives one memory transaction at a time. It generates byte enables and
//  aligns load data with sign or zero extension. It returns a per-lane completion.
// PARAMETERS
//  NLANES     2    number of LSU lanes sharing the port (>=1)
//  ADDR_W     32   byte-address width
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst_n         in   1          asynchronous active-low reset
//  req_valid     in   NLANES     lane has a memory op pending
//  req_ready     out  NLANES     one-hot grant; the op is accepted when valid&ready
//  req_is_load   in   NLANES     1=load, 0=store
//  req_zero_ext  in   NLANES     load zero-extends (LBU/LHU)
//  req_size      in   2*NLANES   0=byte 1=half 2=word, 3 treated as word
//  req_rd        in   5*NLANES   load destination register
//  req_addr      in   ADDR_W*NLANES  byte address
//  req_wdata     in   32*NLANES  store data, LSB-justified
//  resp_valid    out  NLANES     one-cycle completion pulse to owning lane
//  resp_rd       out  5          rd of completed op (0 for stores)
//  resp_data     out  32         extended load data (0 for stores/errors)
//  resp_err      out  1          misaligned access, valid with resp_valid
//  mem_req       out  1          memory request, held until mem_gnt
//  mem_we        out  1          1=write
//  mem_addr      out  ADDR_W     word-aligned address {addr[ADDR_W-1:2],2'b00}
//  mem_be        out  4          byte enables
//  mem_wdata     out  32         store data replicated into lane position
//  mem_gnt       in   1          memory accepts request this cycle
//  mem_rvalid    in   1          read data valid; arrives >=1 cycle after gnt
//  mem_rdata     in   32         read word
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0, and every output is 0, immediately (async).
//  FSM IDLE -> ISSUE -> (load) WAIT_R -> RESP -> IDLE; (store) ISSUE -> RESP -> IDLE.
//  IDLE: req_ready is combinational and one-hot. It selects the first valid lane at
//    or after rr_ptr. Accepting an op latches its fields and sets rr_ptr=winner+1 mod NLANES.
//    The misalignment check (half: addr[0]!=0; word: addr[1:0]!=0) is done on acceptance.
//    A misaligned op goes directly to RESP with err=1 and never asserts mem_req.
//  ISSUE: mem_req=1 with stable we/addr/be/wdata until mem_gnt is asserted. Store -> RESP. Load -> WAIT_R.
//  WAIT_R: the block waits for mem_rvalid, captures mem_rdata, then goes to RESP.
//  RESP: resp_valid[owner]=1 for exactly one cycle with rd/data/err. The next state is IDLE.
//  req_ready is 0 in every state except IDLE. Maximum throughput is one op per 3 cycles
//    for a store with mem_gnt on the first ISSUE cycle.
//  Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//  wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Load extract: select the byte/half given by a[1:0], then sign-extend, or zero-extend
//    when zero_ext=1. zero_ext is ignored for word loads.
//  mem_rvalid outside WAIT_R and mem_gnt outside ISSUE are ignored.
//  A lane dropping req_valid without a handshake loses nothing. A lane may re-request
//    in the cycle after its own resp_valid.
//  The arbiter is starvation-free: with N lanes all valid, each lane is served within
//    N accepted ops.
// STRUCTURE
//  lsu_pkg: lsu_size_e {SZ_B,SZ_H,SZ_W}, lsu_state_e {IDLE,ISSUE,WAIT_R,RESP},
//    constant OP_LOAD=7'b0000011 and function lsu_be(size,a).
//  Sub-module lsu_rr_arbiter #(N): req[N], ptr, advance -> one-hot gnt, index.
//  The FSM, operation latch and data alignment stay in this module.
// TESTING
//  1. Lane0 stores SB at addr 0x1003, data 0xAB, mem_gnt on 2nd ISSUE cycle
//     -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, resp_valid[0] 1 cycle after gnt.
//  2. LB at addr 0x2001 with rdata=0x00008000 -> data 0xFFFFFF80; same with LBU -> 0x00000080.
//     LH at 0x2002 with rdata=0x8001_0000 -> data 0xFFFF8001.
//  3. Two lanes held valid for 4 ops -> grants alternate 0,1,0,1, and no lane is granted twice
//     while the other waits.
//  4. LW at 0x3002 -> resp_err=1, resp_data=0, mem_req never asserted.
//  5. rst_n low during WAIT_R -> all outputs 0 in the same cycle. A late mem_rvalid
//     after release gives no resp_valid, and the next op uses lane 0.
//  6. Spurious mem_rvalid in IDLE with req_valid=0 -> no state change, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Purpose: shared types, constants and byte-lane helpers for the LSU memory
//          arbiter (access size, FSM state, byte enables, store replication,
//          misalignment test and load-data extraction/extension).
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } lsu_state_e;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  // Raw size code 3 is not a legal encoding; it behaves as a word access.
  function automatic lsu_size_e lsu_size(input logic [1:0] raw);
    lsu_size_e s;
    case (raw)
      2'd0:    s = SZ_B;
      2'd1:    s = SZ_H;
      default: s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] lsu_be(input lsu_size_e size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] a);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = a[0];
      default: mis = |a;
    endcase
    return mis;
  endfunction

  // Replicate the LSB-justified store data into every lane it could occupy,
  // so the byte enables alone pick the written bytes.
  function automatic logic [31:0] lsu_wdata(input lsu_size_e size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lsu_extract(input lsu_size_e size, input logic zext,
                                              input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_B:    r = zext ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    r = zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_rr_arbiter.sv
// Purpose: round-robin arbiter with internal pointer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointer -> 0)
//   i_req       request vector
//   i_advance   a grant was taken this cycle; pointer moves past the winner
//   o_gnt       one-hot grant: first requester at or after the pointer
//   o_idx       index of the granted requester (0 when none)
module lsu_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0]  r_ptr;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_sh;
  logic [N-1:0]   w_rot;
  logic [IW:0]    w_sum;
  logic           w_found;
  logic [IW-1:0]  w_idx;

  // Rotate the request vector so the pointer position sits at bit 0; the
  // first set bit then gives the distance from the pointer to the winner.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_sh    = w_dbl >> r_ptr;
    w_rot   = w_sh[N-1:0];
    w_found = 1'b0;
    w_sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IW+1)'(k);
      end
    end
    w_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
    o_gnt = '0;
    for (int unsigned c = 0; c < N; c++) begin
      o_gnt[c] = w_found && (w_idx == IW'(c));
    end
  end

  assign o_idx = w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Purpose: shares one data-memory port between NLANES LSU lanes. Round-robin
//          accepts one op at a time, issues it with byte enables and replicated
//          store data, extracts/extends load data and pulses a per-lane response.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-lane handshake (ready is one-hot, IDLE only)
//   req_is_load, req_zero_ext   op kind and load extension
//   req_size, req_rd            access size code and load destination
//   req_addr, req_wdata         byte address and LSB-justified store data
//   resp_valid/rd/data/err      one-cycle completion to the owning lane
//   mem_req/we/addr/be/wdata    memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory accept and read return
module lsu_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned NLANES = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NLANES-1:0]      req_valid,
  output logic [NLANES-1:0]      req_ready,
  input  logic [NLANES-1:0]      req_is_load,
  input  logic [NLANES-1:0]      req_zero_ext,
  input  logic [2*NLANES-1:0]    req_size,
  input  logic [5*NLANES-1:0]    req_rd,
  input  logic [ADDR_W*NLANES-1:0] req_addr,
  input  logic [32*NLANES-1:0]   req_wdata,
  output logic [NLANES-1:0]      resp_valid,
  output logic [4:0]             resp_rd,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [3:0]             mem_be,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata
);

  localparam int unsigned IW = (NLANES > 1) ? $clog2(NLANES) : 1;

  lsu_state_e r_state, w_state_nxt;

  logic [NLANES-1:0] w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_accept;

  logic              w_sel_load;
  logic              w_sel_zext;
  lsu_size_e         w_sel_size;
  logic [4:0]        w_sel_rd;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_sel_mis;

  logic [IW-1:0]     r_owner;
  logic              r_is_load;
  logic              r_zext;
  lsu_size_e         r_size;
  logic [4:0]        r_rd;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_boff;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  lsu_rr_arbiter #(
    .N (NLANES)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_advance (w_accept),
    .o_gnt     (w_gnt),
    .o_idx     (w_idx)
  );

  assign w_accept = (r_state == IDLE) && (|w_gnt);

  assign w_sel_load  = req_is_load[w_idx];
  assign w_sel_zext  = req_zero_ext[w_idx];
  assign w_sel_size  = lsu_size(req_size[2*w_idx +: 2]);
  assign w_sel_rd    = req_rd[5*w_idx +: 5];
  assign w_sel_addr  = req_addr[ADDR_W*w_idx +: ADDR_W];
  assign w_sel_wdata = req_wdata[32*w_idx +: 32];
  assign w_sel_mis   = lsu_misaligned(w_sel_size, w_sel_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are decoded from the state and gated to zero elsewhere, so an
  // asynchronous reset clears them without waiting for a clock edge. The
  // ready path is combinational from req_valid, hence the extra rst_n gate.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    resp_valid  = '0;
    resp_rd     = '0;
    resp_data   = '0;
    resp_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          req_ready = w_gnt;
        end
        if (w_accept) begin
          w_state_nxt = w_sel_mis ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = ~r_is_load;
        mem_addr  = r_addr;
        mem_be    = r_be;
        mem_wdata = r_wdata;
        if (mem_gnt) begin
          w_state_nxt = r_is_load ? WAIT_R : RESP;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid  = NLANES'(1) << r_owner;
        resp_rd     = r_rd;
        resp_data   = r_rdata;
        resp_err    = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= '0;
      r_is_load <= 1'b0;
      r_zext    <= 1'b0;
      r_size    <= SZ_B;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_boff    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else if (w_accept) begin
      r_owner   <= w_idx;
      r_is_load <= w_sel_load;
      r_zext    <= w_sel_zext;
      r_size    <= w_sel_size;
      r_rd      <= w_sel_load ? w_sel_rd : '0;
      r_err     <= w_sel_mis;
      r_addr    <= {w_sel_addr[ADDR_W-1:2], 2'b00};
      r_boff    <= w_sel_addr[1:0];
      r_be      <= lsu_be(w_sel_size, w_sel_addr[1:0]);
      r_wdata   <= w_sel_load ? '0 : lsu_wdata(w_sel_size, w_sel_wdata);
      r_rdata   <= '0;
    end else if (r_state == WAIT_R && mem_rvalid) begin
      r_rdata   <= lsu_extract(r_size, r_zext, r_boff, mem_rdata);
    end
  end

endmodule
